if_id_pipe_reg: RTL and testbench

//  Parametrised IF->ID pipeline register for the MiniMotorway core, replacing the fixed 32-bit stall/flush latch.

---
 rtl/mm_pipe_pkg.sv | 17 +
 rtl/if_id_pipe_reg_if.sv | 31 +++
 rtl/pipe_skid_buf.sv | 50 +++++
 rtl/if_id_pipe_reg.sv | 133 +++++++++++++
 tb/tb_if_id_pipe_reg.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mm_pipe_pkg.sv
// Shared types and constants for the MiniMotorway pipeline registers.
package mm_pipe_pkg;

    // Native datapath width of the core.
    localparam int MM_XLEN = 32;

    // addi x0,x0,0: what the decoder sees whenever a stage carries no beat.
    localparam logic [MM_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction travelling down the front end.
    typedef struct packed {
        logic [MM_XLEN-1:0] pc;
        logic [MM_XLEN-1:0] p4;
        logic [MM_XLEN-1:0] instr;
    } if_id_payload_t;

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Bundle of fetch-side, decode-side and flush signals around the IF->ID register.
// master = the surrounding core (fetch, decoder, EX resolver); slave = the register.
interface if_id_pipe_reg_if
    import mm_pipe_pkg::*;
#(
    parameter int XLEN = MM_XLEN
);
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_p4;
    logic [XLEN-1:0] if_instr;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_p4;
    logic [XLEN-1:0] id_instr;
    logic            flush;
    logic            flush_exempt;
    logic            flush_busy;

    modport master (
        output if_valid, if_pc, if_p4, if_instr, id_ready, flush, flush_exempt,
        input  if_ready, id_valid, id_pc, id_p4, id_instr, flush_busy
    );

    modport slave (
        input  if_valid, if_pc, if_p4, if_instr, id_ready, flush, flush_exempt,
        output if_ready, id_valid, id_pc, id_p4, id_instr, flush_busy
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic single-entry skid buffer: holds one payload while the consumer stalls.
// i_clear empties the entry and wins over a simultaneous write.
module pipe_skid_buf #(
    parameter int W = 96
) (
    input  logic         i_clk,
    input  logic         i_resetn,
    input  logic         i_clear,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         full_reg;
    logic         full_next;
    logic [W-1:0] data_reg;
    logic [W-1:0] data_next;

    // Ready comes straight from the flop so upstream never sees a combinational path.
    assign o_ready = ~full_reg;
    assign o_valid = full_reg;
    assign o_data  = data_reg;

    // Next entry state: clear, then fill, then drain.
    always_comb begin
        full_next = full_reg;
        data_next = data_reg;
        if (i_clear) begin
            full_next = 1'b0;
        end else if (i_valid && o_ready) begin
            full_next = 1'b1;
            data_next = i_data;
        end else if (o_valid && i_ready) begin
            full_next = 1'b0;
        end
    end

    // Entry register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else begin
            full_reg <= full_next;
            data_reg <= data_next;
        end
    end
endmodule

// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with valid/ready on both sides, optional skid entry,
// and a programmable flush bubble. FLUSH_CYCLES must be at least 1.
module if_id_pipe_reg
    import mm_pipe_pkg::*;
#(
    parameter int              XLEN         = MM_XLEN,
    parameter logic [XLEN-1:0] NOP_INSTR    = mm_pipe_pkg::NOP_INSTR,
    parameter int              FLUSH_CYCLES = 2,
    parameter bit              SKID_EN      = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    if_id_pipe_reg_if.slave  bus
);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam int PW    = 3 * XLEN;

    logic             eff_flush;
    logic             busy;
    logic             out_load;
    logic             out_hold;
    logic             acc;
    logic             skid_valid;
    logic             skid_ready;
    logic             skid_push;
    logic             skid_pop;
    logic [PW-1:0]    in_payload;
    logic [PW-1:0]    skid_payload;

    logic             out_valid_reg;
    logic             out_valid_next;
    logic [XLEN-1:0]  out_pc_reg;
    logic [XLEN-1:0]  out_pc_next;
    logic [XLEN-1:0]  out_p4_reg;
    logic [XLEN-1:0]  out_p4_next;
    logic [XLEN-1:0]  out_instr_reg;
    logic [XLEN-1:0]  out_instr_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // An exempt instruction in EX (e.g. AUIPC) masks the flush for this cycle only.
    assign eff_flush  = bus.flush & ~bus.flush_exempt;
    assign busy       = (cnt_reg != '0);
    assign out_load   = ~out_valid_reg | bus.id_ready;
    assign out_hold   = ~out_load;
    assign acc        = bus.if_valid & bus.if_ready & ~eff_flush & ~busy;
    assign in_payload = {bus.if_pc, bus.if_p4, bus.if_instr};

    // Beats accepted while the output is stalled park in the skid entry.
    assign skid_push  = acc & out_hold;
    assign skid_pop   = out_load;

    generate
        if (SKID_EN) begin : g_skid
            pipe_skid_buf #(
                .W (PW)
            ) u_skid (
                .i_clk    (i_clk),
                .i_resetn (i_resetn),
                .i_clear  (eff_flush),
                .i_valid  (skid_push),
                .o_ready  (skid_ready),
                .i_data   (in_payload),
                .o_valid  (skid_valid),
                .i_ready  (skid_pop),
                .o_data   (skid_payload)
            );
            // Registered ready: only the skid occupancy gates upstream.
            assign bus.if_ready = skid_ready & i_resetn;
        end else begin : g_no_skid
            assign skid_valid   = 1'b0;
            assign skid_ready   = 1'b1;
            assign skid_payload = '0;
            // Without a skid entry, ready follows the output slot directly.
            assign bus.if_ready = (~out_valid_reg | bus.id_ready) & i_resetn;
        end
    endgenerate

    assign bus.id_valid   = out_valid_reg;
    assign bus.id_pc      = out_pc_reg;
    assign bus.id_p4      = out_p4_reg;
    assign bus.id_instr   = out_instr_reg;
    assign bus.flush_busy = busy;

    // Next output slot and bubble counter: flush first, then normal load from skid or input.
    always_comb begin
        out_valid_next = out_valid_reg;
        out_pc_next    = out_pc_reg;
        out_p4_next    = out_p4_reg;
        out_instr_next = out_instr_reg;
        cnt_next       = busy ? (cnt_reg - CNT_W'(1)) : cnt_reg;
        if (eff_flush) begin
            // pc/p4 keep the flushed fetch address purely for trace visibility.
            out_valid_next = 1'b0;
            out_pc_next    = bus.if_pc;
            out_p4_next    = bus.if_p4;
            out_instr_next = NOP_INSTR;
            cnt_next       = CNT_W'(FLUSH_CYCLES - 1);
        end else if (out_load) begin
            if (skid_valid) begin
                out_valid_next = 1'b1;
                out_pc_next    = skid_payload[PW-1 -: XLEN];
                out_p4_next    = skid_payload[2*XLEN-1 -: XLEN];
                out_instr_next = skid_payload[XLEN-1:0];
            end else if (acc) begin
                out_valid_next = 1'b1;
                out_pc_next    = bus.if_pc;
                out_p4_next    = bus.if_p4;
                out_instr_next = bus.if_instr;
            end else begin
                out_valid_next = 1'b0;
                out_instr_next = NOP_INSTR;
            end
        end
    end

    // Output slot and counter registers; reset returns to an empty bubble.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            out_valid_reg <= 1'b0;
            out_pc_reg    <= '0;
            out_p4_reg    <= '0;
            out_instr_reg <= NOP_INSTR;
            cnt_reg       <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            out_pc_reg    <= out_pc_next;
            out_p4_reg    <= out_p4_next;
            out_instr_reg <= out_instr_next;
            cnt_reg       <= cnt_next;
        end
    end
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Scoreboard bench for if_id_pipe_reg: the stage is modelled as an ordered
// queue of held beats (at most two) plus a bubble countdown.
module tb_if_id_pipe_reg;
    import mm_pipe_pkg::*;

    localparam int FC = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic resetn;

    if_id_pipe_reg_if #(.XLEN(32)) bus ();

    if_id_pipe_reg #(
        .XLEN         (32),
        .NOP_INSTR    (NOP),
        .FLUSH_CYCLES (FC),
        .SKID_EN      (1'b1)
    ) dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state
    if_id_payload_t sb[$];
    int          bub       = 0;
    bit          exp_ready = 1'b0;
    bit          mon_en    = 1'b0;
    bit          trace_chk = 1'b0;
    logic [31:0] trace_pc  = '0;
    logic [31:0] trace_p4  = '0;

    // What the current cycle will do at the next edge
    bit             pend_rn  = 1'b0;
    bit             pend_eff = 1'b0;
    bit             pend_acc = 1'b0;
    if_id_payload_t pend_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Fold the cycle that just ended into the reference state.
    task automatic apply_model();
        trace_chk = 1'b0;
        if (!pend_rn) begin
            sb.delete();
            bub = 0;
        end else if (pend_eff) begin
            sb.delete();
            bub = FC - 1;
            trace_chk = 1'b1;
            trace_pc = pend_beat.pc;
            trace_p4 = pend_beat.p4;
        end else begin
            if (bub > 0) bub--;
            if (pend_acc) sb.push_back(pend_beat);
        end
    endtask

    task automatic step(input bit rn, input bit iv, input logic [31:0] pc,
                        input logic [31:0] instr, input bit idr, input bit fl, input bit ex);
        bit eff;
        @(posedge clk);
        apply_model();
        mon_en = 1'b1;
        #1;
        resetn           = rn;
        bus.if_valid     = iv;
        bus.if_pc        = pc;
        bus.if_p4        = pc + 32'd4;
        bus.if_instr     = instr;
        bus.id_ready     = idr;
        bus.flush        = fl;
        bus.flush_exempt = ex;
        eff       = fl && !ex;
        exp_ready = rn && (sb.size() < 2);
        pend_rn   = rn;
        pend_eff  = eff;
        pend_acc  = iv && exp_ready && !eff && (bub == 0);
        pend_beat.pc    = pc;
        pend_beat.p4    = pc + 32'd4;
        pend_beat.instr = instr;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 32'h0, 32'h0, 1, 0, 0);
    endtask

    // Monitor: compare presented outputs mid-cycle, pop on each decode handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                bit exp_v;
                exp_v = (sb.size() > 0);
                check("id_valid", {31'd0, bus.id_valid}, {31'd0, exp_v});
                check("if_ready", {31'd0, bus.if_ready}, {31'd0, exp_ready});
                check("flush_busy", {31'd0, bus.flush_busy}, {31'd0, bub != 0});
                if (exp_v) begin
                    check("id_pc", bus.id_pc, sb[0].pc);
                    check("id_p4", bus.id_p4, sb[0].p4);
                    check("id_instr", bus.id_instr, sb[0].instr);
                end else begin
                    check("bubble_instr", bus.id_instr, NOP);
                end
                if (trace_chk) begin
                    check("trace_pc", bus.id_pc, trace_pc);
                    check("trace_p4", bus.id_p4, trace_p4);
                end
                if (exp_v && bus.id_ready) begin
                    $display("beat pc=%h instr=%h delivered at %0t", sb[0].pc, sb[0].instr, $time);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        resetn           = 1'b0;
        bus.if_valid     = 1'b0;
        bus.if_pc        = '0;
        bus.if_p4        = '0;
        bus.if_instr     = '0;
        bus.id_ready     = 1'b0;
        bus.flush        = 1'b0;
        bus.flush_exempt = 1'b0;

        // 1: reset held for three edges, then explicit reset-value checks
        for (int k = 0; k < 3; k++) step(0, 1, 32'hdead_0000, 32'h1234_5678, 1, 0, 0);
        @(negedge clk);
        check("rst_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst_instr", bus.id_instr, NOP);
        check("rst_pc", bus.id_pc, 32'd0);
        check("rst_p4", bus.id_p4, 32'd0);
        check("rst_ready", {31'd0, bus.if_ready}, 32'd0);
        idle(1);

        // 2: back-to-back stream
        for (int k = 0; k < 4; k++) step(1, 1, k * 4, 32'h0010_0093 + k, 1, 0, 0);
        idle(2);

        // 3: stall with second beat landing in the skid
        step(1, 1, 32'h10, 32'hA000_0010, 1, 0, 0);
        step(1, 1, 32'h14, 32'hA000_0014, 0, 0, 0);
        step(1, 1, 32'h18, 32'hA000_0018, 0, 0, 0);
        step(1, 0, 32'h0,  32'h0,         1, 0, 0);
        idle(3);

        // 4: flush with a beat pending, then a beat during the second bubble
        step(1, 1, 32'h20, 32'hB000_0020, 1, 0, 0);
        step(1, 1, 32'h24, 32'hB000_0024, 1, 1, 0);
        step(1, 1, 32'h28, 32'hB000_0028, 1, 0, 0);
        step(1, 1, 32'h2C, 32'hB000_002C, 1, 0, 0);
        idle(2);

        // 5: exempt flush transfers normally; flush with a full skid empties both
        step(1, 1, 32'h30, 32'hC000_0030, 1, 1, 1);
        idle(1);
        step(1, 1, 32'h40, 32'hC000_0040, 1, 0, 0);
        step(1, 1, 32'h44, 32'hC000_0044, 0, 0, 0);
        step(1, 0, 32'h0,  32'h0,         0, 0, 0);
        step(1, 0, 32'h48, 32'h0,         0, 1, 0);
        idle(3);

        // 6: reset while the bubble counter is non-zero
        step(1, 1, 32'h50, 32'hD000_0050, 1, 1, 0);
        step(0, 1, 32'h54, 32'hD000_0054, 1, 0, 0);
        step(1, 1, 32'h58, 32'hD000_0058, 1, 0, 0);
        idle(2);

        // Randomized traffic
        for (int k = 0; k < 800; k++) begin
            bit rn, iv, idr, fl, ex;
            rn  = ($urandom_range(0, 99) != 0);
            iv  = ($urandom_range(0, 9) < 7);
            idr = ($urandom_range(0, 9) < 7);
            fl  = ($urandom_range(0, 99) < 8);
            ex  = fl && ($urandom_range(0, 1) == 1);
            step(rn, iv, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom(), idr, fl, ex);
        end
        idle(4);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
